// File: rtl/wb_burst_pkg.sv
// Shared Wishbone constants and FSM state type for the burst reader.
package wb_burst_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SPACE,
        BURST
    } state_e;

endpackage

// File: rtl/wshb_if.sv
// Wishbone B4 bus bundle with master/slave views; clk/rst ride along for slave-side users.
interface wshb_if;

    logic        clk;
    logic        rst;
    logic [31:0] adr;
    logic [31:0] dat_ms;
    logic [31:0] dat_sm;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack;
    logic        err;
    logic        rty;

    modport master (
        input  clk, rst, dat_sm, ack, err, rty,
        output adr, dat_ms, cyc, stb, we, sel, cti, bte
    );

    modport slave (
        input  clk, rst, adr, dat_ms, cyc, stb, we, sel, cti, bte,
        output dat_sm, ack, err, rty
    );

endinterface

// File: rtl/wb_rd_fifo.sv
// Synchronous first-word-fall-through FIFO; head word is visible on data_o while not empty.
module wb_rd_fifo #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] free_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pop_c;

    // Pops on an empty FIFO are dropped; push+pop leaves occupancy unchanged.
    always_comb begin
        pop_c    = pop_i && (cnt_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_i, pop_c})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset; occupancy alone qualifies the head word.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign empty_o = (cnt_q == '0);
    assign free_o  = CNT_W'(DEPTH) - cnt_q;

endmodule

// File: rtl/wb_burst_reader.sv
// Wishbone B4 incrementing-burst frame reader feeding a FWFT output FIFO.
// Optional bus-error abort is enabled by defining WB_BURST_READER_ERR_EN.
module wb_burst_reader
    import wb_burst_pkg::*;
#(
    parameter logic [31:0] BASE_ADR   = 32'h0000_0000,
    parameter int unsigned NB_WORDS   = 1024,
    parameter int unsigned BURST_LEN  = 8,
    parameter int unsigned FIFO_DEPTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    wshb_if.master       wb_m,
    input  logic         start_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [31:0]  data_o,
    output logic         valid_o,
    input  logic         ready_i,
    output logic         err_o
);

    localparam int unsigned IDX_W = $clog2(NB_WORDS + 1);
    localparam int unsigned BL_W  = $clog2(BURST_LEN + 1);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [BL_W-1:0]  beat_left_q, beat_left_d;
    logic             cyc_q, cyc_d;
    logic [31:0]      adr_q, adr_d;
    logic [2:0]       cti_q, cti_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [31:0]      remain_c;
    logic [BL_W-1:0]  blen_c;
    logic [CNT_W-1:0] free_c;
    logic             space_ok_c;
    logic             bus_err_c;
    logic             push_c;
    logic             fifo_empty_c;
    logic [IDX_W-1:0] idx_next_c;

`ifdef WB_BURST_READER_ERR_EN
    assign bus_err_c = wb_m.err;
`else
    assign bus_err_c = 1'b0;
`endif

    assign remain_c   = 32'(NB_WORDS) - 32'(idx_q);
    assign blen_c     = (remain_c < 32'(BURST_LEN)) ? BL_W'(remain_c) : BL_W'(BURST_LEN);
    assign space_ok_c = (32'(free_c) >= 32'(blen_c));
    assign idx_next_c = idx_q + IDX_W'(1);
    assign push_c     = (state_q == BURST) && wb_m.ack && !bus_err_c;

    // A burst is only launched once the FIFO can absorb every beat of it.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        beat_left_d = beat_left_q;
        cyc_d       = cyc_q;
        adr_d       = adr_q;
        cti_d       = cti_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = WAIT_SPACE;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    adr_d   = BASE_ADR;
                end
            end
            WAIT_SPACE: begin
                if (space_ok_c) begin
                    state_d     = BURST;
                    cyc_d       = 1'b1;
                    beat_left_d = blen_c;
                    adr_d       = BASE_ADR + (32'(idx_q) << 2);
                    cti_d       = (blen_c == BL_W'(1)) ? CTI_EOB : CTI_INCR;
                end
            end
            BURST: begin
                if (bus_err_c) begin
                    state_d = IDLE;
                    cyc_d   = 1'b0;
                    cti_d   = CTI_CLASSIC;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                end else if (wb_m.ack) begin
                    idx_d       = idx_next_c;
                    beat_left_d = beat_left_q - BL_W'(1);
                    if (beat_left_q == BL_W'(1)) begin
                        cyc_d = 1'b0;
                        cti_d = CTI_CLASSIC;
                        if (idx_next_c == IDX_W'(NB_WORDS)) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = WAIT_SPACE;
                        end
                    end else begin
                        adr_d = adr_q + 32'd4;
                        cti_d = (beat_left_q == BL_W'(2)) ? CTI_EOB : CTI_INCR;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            beat_left_q <= '0;
            cyc_q       <= 1'b0;
            adr_q       <= BASE_ADR;
            cti_q       <= CTI_CLASSIC;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            beat_left_q <= beat_left_d;
            cyc_q       <= cyc_d;
            adr_q       <= adr_d;
            cti_q       <= cti_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    wb_rd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_c),
        .push_data_i (wb_m.dat_sm),
        .pop_i       (ready_i),
        .data_o      (data_o),
        .empty_o     (fifo_empty_c),
        .free_o      (free_c)
    );

    assign wb_m.cyc    = cyc_q;
    assign wb_m.stb    = cyc_q;
    assign wb_m.we     = 1'b0;
    assign wb_m.sel    = 4'hF;
    assign wb_m.bte    = BTE_LINEAR;
    assign wb_m.dat_ms = '0;
    assign wb_m.adr    = adr_q;
    assign wb_m.cti    = cti_q;

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign err_o   = err_q;
    assign valid_o = !fifo_empty_c;

endmodule

// File: tb/tb_wb_burst_reader.sv
// Directed bench for wb_burst_reader: memory slave with wait/err injection and a data scoreboard.
module tb_wb_burst_reader;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int          NB   = 43;
    localparam int          BL   = 8;
    localparam int          FD   = 16;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] data_o;
    logic        valid_o;
    logic        ready_i;
    logic        err_o;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    int waits    = 0;
    int err_beat = -1;
    int wcnt_q;
    int frame_beats_q;
    logic err_fired_q;

    logic [31:0] sb_q [$];
    logic [34:0] beat_q [$];

    logic        prev_wait;
    logic [31:0] prev_adr;
    logic [2:0]  prev_cti;

    wshb_if wb();

    assign wb.clk = clk;
    assign wb.rst = rst;
    assign wb.rty = 1'b0;

    wb_burst_reader #(
        .BASE_ADR   (BASE),
        .NB_WORDS   (NB),
        .BURST_LEN  (BL),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wb_m    (wb),
        .start_i (start_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .data_o  (data_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .err_o   (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave: mem[i] = i, programmable wait states, one-shot err on a chosen beat.
    assign wb.err    = wb.cyc && wb.stb && !err_fired_q && (frame_beats_q == err_beat);
    assign wb.ack    = wb.cyc && wb.stb && !wb.err && (wcnt_q >= waits);
    assign wb.dat_sm = (wb.adr - BASE) >> 2;

    always @(posedge wb.clk or posedge wb.rst) begin
        if (wb.rst) begin
            wcnt_q        <= 0;
            frame_beats_q <= 0;
            err_fired_q   <= 1'b0;
        end else if (start_i) begin
            frame_beats_q <= 0;
            err_fired_q   <= 1'b0;
            wcnt_q        <= 0;
        end else begin
            if (wb.ack) begin
                wcnt_q        <= 0;
                frame_beats_q <= frame_beats_q + 1;
            end else if (wb.cyc && wb.stb) begin
                wcnt_q <= wcnt_q + 1;
            end
            if (wb.err) err_fired_q <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Monitor: beat log, wait-state hold, scoreboard pops, done pulses.
    always @(negedge clk) begin
        if (rst) begin
            prev_wait = 1'b0;
        end else begin
            if (prev_wait && wb.cyc) begin
                check("hold_adr", wb.adr, prev_adr);
                check("hold_cti", 32'(wb.cti), 32'(prev_cti));
            end
            if (wb.cyc && wb.stb && wb.ack) begin
                beat_q.push_back({wb.adr, wb.cti});
                if (wb.adr == BASE) begin
                    check("we", 32'(wb.we), 32'd0);
                    check("sel", 32'(wb.sel), 32'hF);
                    check("bte", 32'(wb.bte), 32'd0);
                end
            end
            prev_wait = wb.cyc && wb.stb && !wb.ack;
            prev_adr  = wb.adr;
            prev_cti  = wb.cti;
            if (valid_o && ready_i) begin
                check("pop_expected", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) check("data_o", data_o, sb_q.pop_front());
            end
            if (done_o) done_cnt++;
        end
    end

    task automatic start_frame();
        beat_q.delete();
        for (int i = 0; i < NB; i++) sb_q.push_back(32'(i));
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check("busy_after_start", 32'(busy_o), 32'd1);
        check("err_clear_on_start", 32'(err_o), 32'd0);
    endtask

    task automatic wait_done(input int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) @(negedge clk);
        check("done_count", 32'(done_cnt), 32'(d0 + 1));
        check("busy_after_done", 32'(busy_o), 32'd0);
    endtask

    task automatic drain();
        repeat (24) @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        check("valid_drained", 32'(valid_o), 32'd0);
    endtask

    task automatic check_beats(input int n);
        logic [34:0] e;
        logic [2:0]  exp_cti;
        check("beat_count", 32'(beat_q.size()), 32'(n));
        for (int i = 0; i < n && beat_q.size() != 0; i++) begin
            e = beat_q.pop_front();
            exp_cti = ((i % BL) == BL - 1 || i == n - 1) ? 3'b111 : 3'b010;
            check($sformatf("beat%0d_adr", i), e[34:3], BASE + 32'(4 * i));
            check($sformatf("beat%0d_cti", i), 32'(e[2:0]), 32'(exp_cti));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int found;
        rst     = 1'b1;
        start_i = 1'b0;
        ready_i = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cyc", 32'(wb.cyc), 32'd0);
        check("rst_stb", 32'(wb.stb), 32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_adr", wb.adr, BASE);
        check("rst_cti", 32'(wb.cti), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Full frame, zero wait states, consumer always ready.
        start_frame();
        wait_done(1000);
        drain();
        check_beats(NB);

        // Consumer stalled: only two bursts fit in the FIFO.
        ready_i = 1'b0;
        start_frame();
        repeat (200) @(negedge clk);
        check("stall_beats", 32'(beat_q.size()), 32'd16);
        check("stall_cyc", 32'(wb.cyc), 32'd0);
        check("stall_valid", 32'(valid_o), 32'd1);
        check("stall_head", data_o, 32'd0);
        check("stall_busy", 32'(busy_o), 32'd1);
        ready_i = 1'b1;
        wait_done(1000);
        drain();
        check_beats(NB);

        // Two wait states per beat.
        waits = 2;
        start_frame();
        wait_done(3000);
        drain();
        check_beats(NB);
        waits = 0;

        // Reset during the third beat of the first burst.
        start_frame();
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            @(negedge clk);
            if (wb.cyc && wb.adr == BASE + 32'd8) found = 1;
        end
        check("beat3_reached", 32'(found), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("midrst_cyc", 32'(wb.cyc), 32'd0);
        check("midrst_stb", 32'(wb.stb), 32'd0);
        check("midrst_valid", 32'(valid_o), 32'd0);
        check("midrst_busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        found = done_cnt;
        repeat (5) @(negedge clk);
        check("midrst_no_done", 32'(done_cnt), 32'(found));
        start_frame();
        wait_done(1000);
        drain();
        check_beats(NB);

        // Bus error on the fifth beat.
        err_beat = 4;
        start_frame();
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            @(negedge clk);
            if (wb.err) found = 1;
        end
        check("err_beat_adr", wb.adr, BASE + 32'd16);
        @(negedge clk);
`ifdef WB_BURST_READER_ERR_EN
        check("err_cyc_drop", 32'(wb.cyc), 32'd0);
        check("err_flag", 32'(err_o), 32'd1);
        check("err_busy", 32'(busy_o), 32'd0);
        found = done_cnt;
        repeat (30) @(negedge clk);
        check("err_no_done", 32'(done_cnt), 32'(found));
        check("err_beats", 32'(beat_q.size()), 32'd4);
        check("err_sb_left", 32'(sb_q.size()), 32'(NB - 4));
        check("err_sticky", 32'(err_o), 32'd1);
        sb_q.delete();
        err_beat = -1;
        start_frame();
        wait_done(1000);
        drain();
        check_beats(NB);
`else
        check("noerr_cyc_held", 32'(wb.cyc), 32'd1);
        check("noerr_flag", 32'(err_o), 32'd0);
        wait_done(1000);
        drain();
        check_beats(NB);
        check("noerr_flag_end", 32'(err_o), 32'd0);
        err_beat = -1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
